// File: rtl/pp_column_serial_acc.sv
// Column-serial summation of a radix-4 Booth partial-product array: bits are binned into
// weighted columns and reduced LSB first, COLS_PER_CYCLE columns per cycle, with a running carry.
module pp_column_serial_acc #(
  parameter int BITWIDTH       = 8,
  parameter int LEASTSIGNIFCOL = 0,
  parameter int SHIFTDISTANCE  = 2,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITWIDTH:0]       pp_array [BITWIDTH/2],
  input  logic [BITWIDTH/2-1:0]   corr,
  input  logic [1:0]              shift_possible,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BITWIDTH-1:0]   out_product,
  output logic [BITWIDTH-1:0]     out_trunc
);

  localparam int ROWS = BITWIDTH / 2;
  localparam int COLS = 2 * BITWIDTH;
  localparam int CW   = $clog2(BITWIDTH) + 2;
  localparam int IW   = $clog2(COLS + 1);

  // Sign-extension ones: column BITWIDTH plus every other column above it.
  function automatic logic [COLS-1:0] sext_const();
    logic [COLS-1:0] v;
    v = '0;
    v[BITWIDTH] = 1'b1;
    for (int i = 0; i < ROWS; i++) v[BITWIDTH + 1 + 2*i] = 1'b1;
    return v;
  endfunction

  localparam logic [COLS-1:0] SEXT = sext_const();

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic [BITWIDTH:0]   pp_reg [ROWS];
  logic [ROWS-1:0]     corr_reg;
  logic [1:0]          sp_reg;
  logic [1:0]          mode_reg;
  logic [CW-1:0]       carry_reg;
  logic [CW-1:0]       carry_next;
  logic [IW-1:0]       col_reg;
  logic [COLS-1:0]     prod_reg;
  logic [COLS-1:0]     prod_next;
  logic [ROWS-1:0][COLS-1:0] row_sh;
  logic [ROWS-1:0][COLS-1:0] corr_sh;
  logic [COLS-1:0]     mode_vec;
  logic [CW-1:0]       col_count [COLS];
  logic [CW:0]         sum;
  int                  idx;
  logic                last_step;

  // Place each row and its correction bit at weight 2^(2i); bits past the top column fall off.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_sh[gi]  = COLS'(pp_reg[gi]) << (2*gi);
      assign corr_sh[gi] = COLS'(corr_reg[gi]) << (2*gi);
    end
  endgenerate

  always_comb begin
    mode_vec = '0;
    case (mode_reg)
      2'd1: mode_vec[BITWIDTH-1] = 1'b1;
      2'd2: begin
        mode_vec[BITWIDTH-SHIFTDISTANCE-1] = ~(sp_reg[1] | sp_reg[0]);
        mode_vec[BITWIDTH-1]               = sp_reg[1] ^ sp_reg[0];
        mode_vec[BITWIDTH+SHIFTDISTANCE-1] = sp_reg[1] & sp_reg[0];
      end
      default: mode_vec = '0;
    endcase
  end

  // Column heights (popcount of each column's bit set).
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      col_count[c] = CW'(SEXT[c]) + CW'(mode_vec[c]);
      for (int i = 0; i < ROWS; i++) begin
        col_count[c] = col_count[c] + CW'(row_sh[i][c]) + CW'(corr_sh[i][c]);
      end
    end
  end

  always_comb begin
    carry_next = carry_reg;
    prod_next  = prod_reg;
    sum        = '0;
    idx        = 0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx = int'(col_reg) + k;
      if (idx < COLS) begin
        sum            = {1'b0, col_count[idx]} + {1'b0, carry_next};
        prod_next[idx] = sum[0];
        carry_next     = sum[CW:1];
      end
    end
  end

  assign last_step = (int'(col_reg) == COLS - COLS_PER_CYCLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      prod_reg      <= '0;
      carry_reg     <= '0;
      col_reg       <= IW'(LEASTSIGNIFCOL);
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            pp_reg       <= pp_array;
            corr_reg     <= corr;
            sp_reg       <= shift_possible;
            mode_reg     <= mode;
            carry_reg    <= '0;
            col_reg      <= IW'(LEASTSIGNIFCOL);
            prod_reg     <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          prod_reg  <= prod_next;
          carry_reg <= carry_next;
          if (last_step) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            col_reg <= col_reg + IW'(COLS_PER_CYCLE);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_product = prod_reg;
  assign out_trunc   = prod_reg[COLS-1:BITWIDTH];

endmodule

// File: tb/tb_pp_column_serial_acc.sv
// Bench for pp_column_serial_acc: three instances (default, LSC=4, CPC=2) checked against
// an arithmetic weighted-sum reference model.
module tb_pp_column_serial_acc;

  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [BW:0]          pp [BW/2];
  logic [BW/2-1:0]      corr;
  logic [1:0]           sp;
  logic [1:0]           mode;
  logic [2:0]           iv, ir, ov, ordy;
  logic [2:0][2*BW-1:0] prod;
  logic [2:0][BW-1:0]   trunc;

  int checks = 0;
  int errors = 0;

  pp_column_serial_acc #(.BITWIDTH(BW), .LEASTSIGNIFCOL(0), .SHIFTDISTANCE(2), .COLS_PER_CYCLE(1)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .pp_array(pp), .corr(corr),
    .shift_possible(sp), .mode(mode), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_product(prod[0]), .out_trunc(trunc[0]));

  pp_column_serial_acc #(.BITWIDTH(BW), .LEASTSIGNIFCOL(4), .SHIFTDISTANCE(2), .COLS_PER_CYCLE(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .pp_array(pp), .corr(corr),
    .shift_possible(sp), .mode(mode), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_product(prod[1]), .out_trunc(trunc[1]));

  pp_column_serial_acc #(.BITWIDTH(BW), .LEASTSIGNIFCOL(0), .SHIFTDISTANCE(2), .COLS_PER_CYCLE(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .pp_array(pp), .corr(corr),
    .shift_possible(sp), .mode(mode), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_product(prod[2]), .out_trunc(trunc[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lsc_of(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  // Handshake cycle t -> out_valid in cycle t+1+(2*BW-LSC)/CPC.
  function automatic int lat_of(input int d);
    int cpc;
    cpc = (d == 2) ? 2 : 1;
    return 1 + (2*BW - lsc_of(d)) / cpc;
  endfunction

  // Weighted sum of every bit and constant, with weights below LSC dropped, mod 2^(2*BW).
  function automatic logic [2*BW-1:0] ref_model(input int lsc);
    longint acc;
    longint m;
    acc = 0;
    m = ~((longint'(1) << lsc) - 1);
    for (int i = 0; i < BW/2; i++) begin
      acc += (longint'(pp[i]) << (2*i)) & m;
      acc += (longint'(corr[i]) << (2*i)) & m;
      acc += (longint'(1) << (BW + 1 + 2*i)) & m;
    end
    acc += (longint'(1) << BW) & m;
    if (mode == 2'd1) acc += (longint'(1) << (BW-1)) & m;
    if (mode == 2'd2) begin
      acc += (longint'(!(sp[1] | sp[0])) << (BW-3)) & m;
      acc += (longint'(sp[1] ^ sp[0]) << (BW-1)) & m;
      acc += (longint'(sp[1] & sp[0]) << (BW+1)) & m;
    end
    return acc[2*BW-1:0];
  endfunction

  task automatic zero_inputs();
    for (int i = 0; i < BW/2; i++) pp[i] = '0;
    corr = '0;
    sp   = '0;
    mode = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < BW/2; i++) pp[i] = (BW+1)'($urandom);
    corr = (BW/2)'($urandom);
    sp   = 2'($urandom_range(0, 3));
    mode = 2'($urandom_range(0, 3));
  endtask

  // Called #1 after a rising edge with inputs already set up.
  task automatic do_txn(input int d, input logic [2*BW-1:0] exp, input string tag, input int hold);
    int w;
    int lat;
    logic [2*BW-1:0] held;
    w = 0;
    while (!ir[d] && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_in_ready"}, 64'(ir[d]), 64'd1);
    iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    rand_inputs();
    lat = 1;
    while (!ov[d] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(lat_of(d)));
    chk({tag, "_product"}, 64'(prod[d]), 64'(exp));
    chk({tag, "_trunc"}, 64'(trunc[d]), 64'(exp[2*BW-1:BW]));
    held = prod[d];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(ov[d]), 64'd1);
      chk({tag, "_hold_busy"}, 64'(ir[d]), 64'd0);
      chk({tag, "_hold_stable"}, 64'(prod[d]), 64'(held));
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk({tag, "_release_valid"}, 64'(ov[d]), 64'd0);
    chk({tag, "_release_ready"}, 64'(ir[d]), 64'd1);
    $display("txn dut=%0d %s product=%04h expected=%04h latency=%0d", d, tag, held, exp, lat);
  endtask

  initial begin
    logic [2*BW-1:0] e;
    int d;
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    zero_inputs();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", 64'(ir[k]), 64'd1);
      chk("reset_out_valid", 64'(ov[k]), 64'd0);
      chk("reset_product", 64'(prod[k]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    zero_inputs();                                  do_txn(0, 16'hAB00, "const_only", 5);
    zero_inputs(); mode = 2'd1;                     do_txn(0, 16'hAB80, "round_half", 0);
    zero_inputs(); mode = 2'd2; sp = 2'b00;         do_txn(0, 16'hAB20, "osfm_sp00", 0);
    zero_inputs(); mode = 2'd2; sp = 2'b01;         do_txn(0, 16'hAB80, "osfm_sp01", 0);
    zero_inputs(); mode = 2'd2; sp = 2'b11;         do_txn(0, 16'hAD00, "osfm_sp11", 0);
    zero_inputs(); mode = 2'd3;                     do_txn(0, 16'hAB00, "mode3", 0);
    zero_inputs(); pp[1] = 9'h003; corr[3] = 1'b1;  do_txn(0, 16'hAB4C, "row_corr", 0);
    zero_inputs(); pp[3] = 9'h1FF;                  do_txn(0, 16'h2AC0, "row_wrap", 1);
    zero_inputs(); pp[0] = 9'h01F;                  do_txn(1, 16'hAB10, "lsc4", 0);
    chk("lsc4_low_nibble", 64'(prod[1][3:0]), 64'd0);
    zero_inputs();                                  do_txn(2, 16'hAB00, "cpc2", 0);

    // Reset in the middle of RUN discards the transaction.
    rand_inputs();
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_valid", 64'(ov[0]), 64'd0);
    chk("midrun_rst_ready", 64'(ir[0]), 64'd1);
    chk("midrun_rst_product", 64'(prod[0]), 64'd0);
    rand_inputs(); e = ref_model(0);                do_txn(0, e, "after_rst", 0);

    for (int n = 0; n < 30; n++) begin
      d = int'($urandom_range(0, 2));
      rand_inputs();
      e = ref_model(lsc_of(d));
      do_txn(d, e, "random", int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_column_serial_acc.md
Name: pp_column_serial_acc

Overview:
- Sequential, parametrised successor to the combinational partial-product pyramid reorder used by the approximate multipliers.
- Accepts one radix-4 Booth partial-product array per transaction, together with correction bits and OSFM shift flags. Places all bits and constants into weighted columns and sums them column-serially, LSB first, `COLS_PER_CYCLE` columns per cycle, with a running carry.
- Replaces the compression tree in area-constrained DNN MAC lanes.
- Runtime mode selects exact, round-to-nearest-half or OSFM compensation. Columns below `LEASTSIGNIFCOL` are dropped as an approximation.

Parameters:
- `BITWIDTH`, 8, operand width; even, ≥4.
- `LEASTSIGNIFCOL`, 0, lowest column summed; columns below contribute nothing; 0 ≤ LSC < BITWIDTH-1.
- `SHIFTDISTANCE`, 2, OSFM compensation distance; 1 ≤ SD < BITWIDTH-1.
- `COLS_PER_CYCLE`, 1, columns processed per RUN cycle; must divide (2*BITWIDTH-LSC).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input transaction valid.
- `in_ready` out 1: block can accept.
- `pp_array` in [BITWIDTH:0] x (BITWIDTH/2): Booth rows; row i has weight 2^(2i); bit BITWIDTH is the pre-inverted sign.
- `corr` in BITWIDTH/2: negation correction; corr[i] has weight 2^(2i).
- `shift_possible` in 2: OSFM shift flags.
- `mode` in 2: 0 exact, 1 round-half, 2 OSFM, 3 treated as 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_product` out 2*BITWIDTH: column-summed result mod 2^(2*BITWIDTH).
- `out_trunc` out BITWIDTH: out_product[2*BITWIDTH-1:BITWIDTH].

Behaviour:
- Reset, including mid-operation: state IDLE, in_ready=1, out_valid=0, out_product=0, carry=0, column index=LSC. Any in-flight data is discarded.
- States:
  - IDLE: in_ready=1. On in_valid, capture the column bit sets, mode and shift_possible, set carry=0 and col=LSC, go to RUN.
  - RUN: in_ready=0. Each cycle process columns col..col+CPC-1 as a combinational ripple. Per column c: s = popcount(bits_c) + carry; out_product[c] = s[0]; carry = s>>1. Then col += CPC. When the last processed column is 2*BITWIDTH-1, go to DONE.
  - DONE: out_valid=1; out_product and out_trunc held stable. On out_ready go to IDLE. in_ready returns the next cycle; there is no same-cycle re-accept.
- Column contents, captured at accept:
  - Row bits: pp_array[i][j] goes to column j+2i. corr[i] goes to column 2i.
  - Sign-extension constant 1s, always: column BITWIDTH, and column BITWIDTH+1+2i for i = 0..BITWIDTH/2-1.
  - Mode 1: one 1 in column BITWIDTH-1.
  - Mode 2:
    - ~(sp[1]|sp[0]) in column BITWIDTH-SD-1.
    - sp[1]^sp[0] in column BITWIDTH-1.
    - sp[1]&sp[0] in column BITWIDTH+SD-1.
- Truncation: bits landing in columns ≥ 2*BITWIDTH are discarded. out_product[LSC-1:0] = 0. The carry out of the top column is discarded.
- Carry register width: $clog2(BITWIDTH)+2, sufficient for max column height BITWIDTH/2+4 plus carry.
- Latency: if the input handshake occurs in cycle t, out_valid rises in cycle t+1+N, where N = (2*BITWIDTH-LSC)/CPC. Example: BW=8, LSC=0, CPC=1 gives t+17.
- Input changes during RUN or DONE are ignored.
- out_ready low in DONE holds the state indefinitely.
- out_ready high outside DONE has no effect.

Test Plan:
(BW=8, SD=2, CPC=1 unless stated; K = 0xAB00 is the sign-extension constant)
1. Constant only: all inputs zero, mode 0 → out_product=0xAB00, out_trunc=0xAB, out_valid exactly 17 cycles after accept.
2. Rounding and OSFM: zero rows with mode 1 → 0xAB80. Mode 2 with sp=00 → 0xAB20. Mode 2 with sp=01 → 0xAB80. Mode 2 with sp=11 → 0xAD00. Mode 3 → 0xAB00.
3. Row and correction placement: pp_array[1]=9'h003, corr[3]=1, mode 0 → 0xAB4C. pp_array[3]=9'h1FF, mode 0 → (0xAB00+0x1FF<<6) mod 2^16 = 0x2AC0.
4. Truncation: LSC=4, pp_array[0]=9'h01F, mode 0 → 0xAB10, low nibble 0, latency 13. Also CPC=2 with LSC=0 → same values as scenario 1, latency 9.
5. Handshake: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Pulse out_ready → in_ready=1 next cycle. Back-to-back transactions produce independent results.
6. Reset mid-RUN: assert rst at cycle t+6 → next cycle out_valid=0, in_ready=1, out_product=0. A new transaction then completes correctly.
